// File: rtl/uart_cmd_parser.sv
// Frames UART bytes (SYNC, OPCODE, ADDR, 4x DATA for writes) into register-access commands.
// Optional CMD_CHECKSUM_EN adds a trailing XOR checksum byte and the err_csum output.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [31:0]       cmd_wdata,
    output logic              err_opcode,
    output logic              err_timeout,
    output logic              err_overrun,
`ifdef CMD_CHECKSUM_EN
    output logic              err_csum,
`endif
    output logic              busy
);

    localparam logic [7:0]  OP_READ  = 8'h01;
    localparam logic [7:0]  OP_WRITE = 8'h02;
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        ADDR,
        DATA,
`ifdef CMD_CHECKSUM_EN
        CSUM,
`endif
        ISSUE
    } state_t;

`ifdef CMD_CHECKSUM_EN
    localparam state_t FRAME_END = CSUM;
`else
    localparam state_t FRAME_END = ISSUE;
`endif

    state_t              state, state_next;
    logic                write_next;
    logic [ADDR_W-1:0]   addr_next;
    logic [31:0]         wdata_next;
    logic [1:0]          bcnt, bcnt_next;
    logic [CNT_W-1:0]    tcnt, tcnt_next;
    logic                timed;
    logic                err_opcode_c, err_timeout_c, err_overrun_c;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]          csum, csum_next;
    logic                err_csum_c;
`endif

    // State, command fields and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_valid   <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            bcnt        <= '0;
            tcnt        <= '0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            csum        <= '0;
            err_csum    <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            cmd_valid   <= (state_next == ISSUE);
            cmd_write   <= write_next;
            cmd_addr    <= addr_next;
            cmd_wdata   <= wdata_next;
            bcnt        <= bcnt_next;
            tcnt        <= tcnt_next;
            err_opcode  <= err_opcode_c;
            err_timeout <= err_timeout_c;
            err_overrun <= err_overrun_c;
            busy        <= (state_next != IDLE);
`ifdef CMD_CHECKSUM_EN
            csum        <= csum_next;
            err_csum    <= err_csum_c;
`endif
        end
    end

    // Next-state and datapath decode
    always_comb begin
        state_next    = state;
        write_next    = cmd_write;
        addr_next     = cmd_addr;
        wdata_next    = cmd_wdata;
        bcnt_next     = bcnt;
        tcnt_next     = '0;
        timed         = 1'b0;
        err_opcode_c  = 1'b0;
        err_timeout_c = 1'b0;
        err_overrun_c = 1'b0;
`ifdef CMD_CHECKSUM_EN
        csum_next     = csum;
        err_csum_c    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_next = OPCODE;
                    wdata_next = '0;
                end
            end
            OPCODE: begin
                timed = 1'b1;
                if (rx_valid) begin
`ifdef CMD_CHECKSUM_EN
                    csum_next = rx_data;
`endif
                    if (rx_data == OP_READ) begin
                        write_next = 1'b0;
                        state_next = ADDR;
                    end else if (rx_data == OP_WRITE) begin
                        write_next = 1'b1;
                        state_next = ADDR;
                    end else begin
                        err_opcode_c = 1'b1;
                        state_next   = IDLE;
                    end
                end
            end
            ADDR: begin
                timed = 1'b1;
                if (rx_valid) begin
                    addr_next = ADDR_W'(rx_data);
`ifdef CMD_CHECKSUM_EN
                    csum_next = csum ^ rx_data;
`endif
                    if (cmd_write) begin
                        bcnt_next  = '0;
                        state_next = DATA;
                    end else begin
                        state_next = FRAME_END;
                    end
                end
            end
            DATA: begin
                timed = 1'b1;
                if (rx_valid) begin
                    wdata_next = {cmd_wdata[23:0], rx_data};
                    bcnt_next  = bcnt + 2'd1;
`ifdef CMD_CHECKSUM_EN
                    csum_next  = csum ^ rx_data;
`endif
                    if (bcnt == 2'd3) begin
                        state_next = FRAME_END;
                    end
                end
            end
`ifdef CMD_CHECKSUM_EN
            CSUM: begin
                timed = 1'b1;
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_next = ISSUE;
                    end else begin
                        err_csum_c = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
`endif
            ISSUE: begin
                // A byte arriving while a command is pending is always lost
                err_overrun_c = rx_valid;
                if (cmd_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Inter-byte timer; a byte in the expiry cycle takes priority
        if (TO_EN && timed && !rx_valid) begin
            if (tcnt == TO_LIMIT) begin
                err_timeout_c = 1'b1;
                state_next    = IDLE;
            end else begin
                tcnt_next = tcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: frame table plus scoreboard of issued commands.
// Builds with or without CMD_CHECKSUM_EN.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        err_opcode;
    logic        err_timeout;
    logic        err_overrun;
    logic        err_csum;
    logic        busy;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (50),
        .ADDR_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .err_opcode  (err_opcode),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
`ifdef CMD_CHECKSUM_EN
        .err_csum    (err_csum),
`endif
        .busy        (busy)
    );

`ifndef CMD_CHECKSUM_EN
    assign err_csum = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic [63:0] bytes;   // frame bytes, left-justified, first byte in [63:56]
        int          n;
        bit          has_cmd;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          n_errop;
    } vec_t;

    cmd_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_hs     = 0;
    int   n_errop  = 0;
    int   n_errto  = 0;
    int   n_errov  = 0;
    int   n_errcs  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard pop on handshake, error pulse counting, exclusivity of error pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                n_hs++;
                if (sb.size() == 0) begin
                    check("unexpected_cmd", {cmd_write, cmd_addr, cmd_wdata}, 64'h0);
                    if ({cmd_write, cmd_addr, cmd_wdata} == 41'h0) begin
                        n_fail++;
                        $display("FAIL unexpected_cmd: got handshake expected none at %0t", $time);
                    end
                end else begin
                    cmd_t e;
                    e = sb.pop_front();
                    check("cmd_fields", {cmd_write, cmd_addr, cmd_wdata}, {e.wr, e.addr, e.wdata});
                end
            end
            if (err_opcode)  n_errop++;
            if (err_timeout) n_errto++;
            if (err_overrun) n_errov++;
            if (err_csum)    n_errcs++;
            if (err_opcode || err_timeout || err_overrun || err_csum)
                check("err_exclusive",
                      64'(int'(err_opcode) + int'(err_timeout) + int'(err_overrun) + int'(err_csum)),
                      64'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) tick();
        check("idle_reached", 64'(busy), 64'd0);
        tick();
        tick();
    endtask

    // Sends a full frame (with checksum byte when enabled); expectation pushed to scoreboard
    task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input bit expect_it);
        logic [7:0] op;
        logic [7:0] cs;
        cmd_t e;
        op = wr ? 8'h02 : 8'h01;
        cs = op ^ addr;
        e.wr = wr;
        e.addr = addr;
        e.wdata = wr ? wdata : 32'h0;
        if (expect_it) sb.push_back(e);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(addr);
        if (wr) begin
            for (int i = 3; i >= 0; i--) begin
                send_byte(wdata[8*i +: 8]);
                cs = cs ^ wdata[8*i +: 8];
            end
        end
`ifdef CMD_CHECKSUM_EN
        send_byte(cs);
`endif
    endtask

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pre_op, pre_to, pre_ov, pre_hs;
        logic [7:0] cs;
        vecs[0] = '{64'hA5013C0000000000, 3, 1'b1, 1'b0, 8'h3C, 32'h0,         0};
        vecs[1] = '{64'hA50210DEADBEEF00, 7, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF,  0};
        vecs[2] = '{64'h00FFA50700000000, 4, 1'b0, 1'b0, 8'h00, 32'h0,         1};
        vecs[3] = '{64'hA501050000000000, 3, 1'b1, 1'b0, 8'h05, 32'h0,         0};
        vecs[4] = '{64'hA502A5A500FF0100, 7, 1'b1, 1'b1, 8'hA5, 32'hA500FF01,  0};
        vecs[5] = '{64'h0AA5AA01FF000000, 5, 1'b0, 1'b0, 8'h00, 32'h0,         1};

        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b1;
        repeat (3) tick();
        check("reset_outputs",
              {cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_opcode, err_timeout,
               err_overrun, err_csum, busy}, 64'h0);
        rst = 1'b0;
        tick();

        // Frame table with cmd_ready held high
        for (int v = 0; v < 6; v++) begin
            pre_op = n_errop;
            if (vecs[v].has_cmd) begin
                cmd_t e;
                e.wr = vecs[v].wr;
                e.addr = vecs[v].addr;
                e.wdata = vecs[v].wdata;
                sb.push_back(e);
            end
            cs = 8'h00;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].bytes[63-8*i -: 8]);
                if (i > 0) cs = cs ^ vecs[v].bytes[63-8*i -: 8];
            end
`ifdef CMD_CHECKSUM_EN
            if (vecs[v].has_cmd) send_byte(cs);
`endif
            wait_idle();
            check($sformatf("vec%0d_err_opcode", v), 64'(n_errop - pre_op), 64'(vecs[v].n_errop));
            check($sformatf("vec%0d_drained", v), 64'(sb.size()), 64'd0);
        end

        // Backpressure: valid held 21 cycles with stable fields, one handshake
        cmd_ready = 1'b0;
        pre_hs = n_hs;
        send_cmd(1'b1, 8'h10, 32'hDEADBEEF, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("bp_held", {cmd_valid, busy, cmd_write, cmd_addr, cmd_wdata},
                  {1'b1, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF});
            tick();
        end
        cmd_ready = 1'b1;
        tick();
        check("bp_released", {cmd_valid, busy}, 64'h0);
        check("bp_one_handshake", 64'(n_hs - pre_hs), 64'd1);
        tick();

        // Timeout: silence after ADDR abandons the frame
        pre_to = n_errto;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h20);
        repeat (49) tick();
        check("to_not_yet", {err_timeout, busy}, {1'b0, 1'b1});
        tick();
        check("to_pulse", {err_timeout, busy}, {1'b1, 1'b0});
        tick();
        check("to_single", 64'(n_errto - pre_to), 64'd1);
        send_cmd(1'b0, 8'h20, 32'h0, 1'b1);
        wait_idle();
        check("to_recover_drained", 64'(sb.size()), 64'd0);

        // Byte in the expiry cycle wins
        pre_to = n_errto;
        sb.push_back('{1'b1, 8'h20, 32'hDEADBEEF});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h20);
        repeat (49) tick();
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h02 ^ 8'h20 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
        wait_idle();
        check("to_edge_none", 64'(n_errto - pre_to), 64'd0);
        check("to_edge_drained", 64'(sb.size()), 64'd0);

        // Overrun while pending: command unchanged
        cmd_ready = 1'b0;
        pre_ov = n_errov;
        send_cmd(1'b0, 8'h77, 32'h0, 1'b1);
        send_byte(8'h55);
        send_byte(8'hA5);
        tick();
        check("ov_count", 64'(n_errov - pre_ov), 64'd2);
        check("ov_cmd_kept", {cmd_valid, cmd_write, cmd_addr, cmd_wdata}, {1'b1, 1'b0, 8'h77, 32'h0});
        cmd_ready = 1'b1;
        wait_idle();
        check("ov_drained", 64'(sb.size()), 64'd0);

        // Overrun in the same cycle as the handshake
        pre_ov = n_errov;
        pre_hs = n_hs;
        send_cmd(1'b0, 8'h66, 32'h0, 1'b1);
        send_byte(8'h11);
        wait_idle();
        check("ov_hs_count", 64'(n_errov - pre_ov), 64'd1);
        check("ov_hs_handshake", 64'(n_hs - pre_hs), 64'd1);

        // Reset mid-DATA: all outputs clear, no error pulse
        pre_op = n_errop; pre_to = n_errto; pre_ov = n_errov;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h30);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_data_outputs",
              {cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_opcode, err_timeout,
               err_overrun, err_csum, busy}, 64'h0);
        repeat (60) tick();
        check("rst_data_no_err", 64'((n_errop - pre_op) + (n_errto - pre_to) + (n_errov - pre_ov)), 64'd0);

        // Reset mid-ISSUE discards the pending command
        cmd_ready = 1'b0;
        pre_hs = n_hs;
        send_cmd(1'b1, 8'h44, 32'h01020304, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmd_ready = 1'b1;
        repeat (3) tick();
        check("rst_issue_discard", {64'(n_hs - pre_hs)}, 64'd0);
        check("rst_issue_outputs", {cmd_valid, cmd_write, cmd_addr, cmd_wdata, busy}, 64'h0);

`ifdef CMD_CHECKSUM_EN
        // Checksum good and bad
        sb.push_back('{1'b0, 8'h3C, 32'h0});
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h3C); send_byte(8'h3D);
        wait_idle();
        check("csum_good_drained", 64'(sb.size()), 64'd0);
        pre_hs = n_hs;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h3C); send_byte(8'h00);
        check("csum_bad_pulse", {err_csum, cmd_valid}, {1'b1, 1'b0});
        wait_idle();
        check("csum_bad_count", 64'(n_errcs), 64'd1);
        check("csum_bad_no_cmd", 64'(n_hs - pre_hs), 64'd0);
`else
        check("no_csum_pulses", 64'(n_errcs), 64'd0);
`endif

        check("final_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
